// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin two-master Avalon-MM arbiter sharing the CPU memory slave between
// instruction fetch and data load/store, with a stall watchdog and sticky bus error.
module mips_cpu_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_address,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    input  logic [3:0]  i_byteenable,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,

    output logic        bus_error
);
    localparam int unsigned  CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        ABORT   = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } bus_req_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;     // last tie winner was the data master
    logic          abort_d_q, abort_d_d;   // owner of the transfer being aborted is D
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_error_q, bus_error_d;

    logic     i_req, d_req, owner_req;
    bus_req_t i_bus, d_bus, s_bus;

    assign i_req     = i_read | i_write;
    assign d_req     = d_read | d_write;
    assign owner_req = (state_q == GRANT_D) ? d_req : i_req;
    assign i_bus     = {i_address, i_read, i_write, i_writedata, i_byteenable};
    assign d_bus     = {d_address, d_read, d_write, d_writedata, d_byteenable};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            abort_d_q   <= 1'b0;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            abort_d_q   <= abort_d_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Arbitration, completion and watchdog.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        abort_d_d   = abort_d_q;
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_req && d_req) begin
                    if (last_d_q) begin
                        state_d  = GRANT_I;
                        last_d_d = 1'b0;
                    end else begin
                        state_d  = GRANT_D;
                        last_d_d = 1'b1;
                    end
                end else if (i_req) begin
                    state_d = GRANT_I;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                // A dropped request is abandoned silently; completion wins over timeout.
                if (!owner_req || !s_waitrequest) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ABORT;
                    cnt_d       = CNT_SAT;
                    abort_d_d   = (state_q == GRANT_D);
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ABORT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux and master responses, decoded from the registered state.
    always_comb begin
        s_bus         = '0;
        i_waitrequest = 1'b1;
        i_readdata    = '0;
        d_waitrequest = 1'b1;
        d_readdata    = '0;
        case (state_q)
            GRANT_I: begin
                s_bus         = i_bus;
                i_waitrequest = s_waitrequest;
                i_readdata    = s_readdata;
            end
            GRANT_D: begin
                s_bus         = d_bus;
                d_waitrequest = s_waitrequest;
                d_readdata    = s_readdata;
            end
            ABORT: begin
                if (abort_d_q) begin
                    d_waitrequest = 1'b0;
                    d_readdata    = 32'hFFFF_FFFF;
                end else begin
                    i_waitrequest = 1'b0;
                    i_readdata    = 32'hFFFF_FFFF;
                end
            end
            default: ;
        endcase
    end

    assign {s_address, s_read, s_write, s_writedata, s_byteenable} = s_bus;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scenario bench for mips_cpu_bus_arbiter: directed cases plus randomized
// transfer streams checked against a service-order model of the arbiter.
module tb_mips_cpu_bus_arbiter;
    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset;
    logic [31:0] i_address, i_writedata, i_readdata;
    logic        i_read, i_write, i_waitrequest;
    logic [3:0]  i_byteenable;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic        d_read, d_write, d_waitrequest;
    logic [3:0]  d_byteenable;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  stall;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    int   ci, cd;

    mips_cpu_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_writedata(i_writedata), .i_byteenable(i_byteenable),
        .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_masters();
        i_read = 1'b0; i_write = 1'b0; i_address = '0; i_writedata = '0; i_byteenable = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    endtask

    task automatic drive_heads();
        idle_masters();
        if (ci < iq.size()) begin
            i_address = iq[ci].addr; i_read = !iq[ci].wr; i_write = iq[ci].wr;
            i_writedata = iq[ci].wdata; i_byteenable = iq[ci].be;
        end
        if (cd < dq.size()) begin
            d_address = dq[cd].addr; d_read = !dq[cd].wr; d_write = dq[cd].wr;
            d_writedata = dq[cd].wdata; d_byteenable = dq[cd].be;
        end
    endtask

    function automatic txn_t rand_txn(logic is_d);
        txn_t t;
        t.addr  = {is_d, 31'($urandom)};
        t.wr    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.be    = 4'($urandom);
        t.stall = 2'($urandom_range(0, 3));
        return t;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        idle_masters();
        i_read = 1'b1; d_write = 1'b1; i_address = 32'h1234_5678;
        s_waitrequest = 1'b1; s_readdata = $urandom;
        next_cycle();
        next_cycle();
        idle_masters();
        sample();
        checks++;
        if ({s_read, s_write} !== 2'b00) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00", {s_read, s_write});
        end
        checks++;
        if ({s_address, s_writedata, s_byteenable} !== 68'h0) begin
            errors++;
            $display("FAIL reset_s_bus: got %h expected 0", {s_address, s_writedata, s_byteenable});
        end
        checks++;
        if ({i_waitrequest, d_waitrequest} !== 2'b11) begin
            errors++;
            $display("FAIL reset_waitrequest: got %b expected 11", {i_waitrequest, d_waitrequest});
        end
        checks++;
        if ({i_readdata, d_readdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_readdata: got %h expected 0", {i_readdata, d_readdata});
        end
        checks++;
        if (bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus_error: got %b expected 0", bus_error);
        end
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_single_iread();
        logic [31:0] word;
        word = $urandom;
        next_cycle();
        i_read = 1'b1; i_address = 32'hBFC0_0000; i_byteenable = 4'hF; s_waitrequest = 1'b1;
        sample();
        checks++;
        if (s_read !== 1'b0) begin
            errors++;
            $display("FAIL iread_latency: got s_read=%b expected 0", s_read);
        end
        next_cycle();
        sample();
        checks++;
        if ({s_read, s_write, s_address} !== {1'b1, 1'b0, 32'hBFC0_0000}) begin
            errors++;
            $display("FAIL iread_grant: got %h expected %h", {s_read, s_write, s_address}, {1'b1, 1'b0, 32'hBFC0_0000});
        end
        checks++;
        if ({i_waitrequest, d_waitrequest} !== 2'b11) begin
            errors++;
            $display("FAIL iread_stall_wait: got %b expected 11", {i_waitrequest, d_waitrequest});
        end
        next_cycle();
        s_waitrequest = 1'b0; s_readdata = word;
        sample();
        checks++;
        if ({i_waitrequest, i_readdata} !== {1'b0, word}) begin
            errors++;
            $display("FAIL iread_data: got %h expected %h", {i_waitrequest, i_readdata}, {1'b0, word});
        end
        checks++;
        if ({d_waitrequest, d_readdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL iread_d_blocked: got %h expected %h", {d_waitrequest, d_readdata}, {1'b1, 32'h0});
        end
        next_cycle();
        idle_masters(); s_waitrequest = 1'b1;
        sample();
        checks++;
        if (s_read !== 1'b0) begin
            errors++;
            $display("FAIL iread_idle_after: got s_read=%b expected 0", s_read);
        end
    endtask

    task automatic test_tie();
        logic        first_i;
        logic        win_i;
        logic [31:0] ai, ad, wi, wd;
        first_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ai = {1'b0, 31'($urandom)}; ad = {1'b1, 31'($urandom)};
            wi = $urandom; wd = $urandom;
            next_cycle();
            i_read = 1'b1; i_address = ai; d_read = 1'b1; d_address = ad; s_waitrequest = 1'b1;
            sample();
            for (int k = 0; k < 2; k++) begin
                win_i = (k == 0) ? first_i : !first_i;
                next_cycle();
                s_waitrequest = 1'b0; s_readdata = win_i ? wi : wd;
                sample();
                checks++;
                if ({s_read, s_address} !== {1'b1, (win_i ? ai : ad)}) begin
                    errors++;
                    $display("FAIL tie_grant r%0d k%0d: got %h expected %h", r, k,
                             {s_read, s_address}, {1'b1, (win_i ? ai : ad)});
                end
                checks++;
                if (win_i) begin
                    if ({i_waitrequest, i_readdata, d_waitrequest} !== {1'b0, wi, 1'b1}) begin
                        errors++;
                        $display("FAIL tie_resp_i r%0d: got %h expected %h", r,
                                 {i_waitrequest, i_readdata, d_waitrequest}, {1'b0, wi, 1'b1});
                    end
                end else begin
                    if ({d_waitrequest, d_readdata, i_waitrequest} !== {1'b0, wd, 1'b1}) begin
                        errors++;
                        $display("FAIL tie_resp_d r%0d: got %h expected %h", r,
                                 {d_waitrequest, d_readdata, i_waitrequest}, {1'b0, wd, 1'b1});
                    end
                end
                next_cycle();
                if (win_i) i_read = 1'b0; else d_read = 1'b0;
                s_waitrequest = 1'b1;
                sample();
                checks++;
                if ({s_read, s_write} !== 2'b00) begin
                    errors++;
                    $display("FAIL tie_gap r%0d k%0d: got %b expected 00", r, k, {s_read, s_write});
                end
            end
            first_i = !first_i;
        end
        idle_masters();
    endtask

    task automatic test_dwrite();
        logic [31:0] wdata;
        wdata = $urandom;
        next_cycle();
        d_write = 1'b1; d_address = 32'h0000_1004; d_writedata = wdata; d_byteenable = 4'b0011;
        s_waitrequest = 1'b1;
        sample();
        checks++;
        if (s_write !== 1'b0) begin
            errors++;
            $display("FAIL dwrite_latency: got s_write=%b expected 0", s_write);
        end
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            s_waitrequest = (j < 2);
            sample();
            checks++;
            if ({s_write, s_read, s_address, s_writedata, s_byteenable} !==
                {1'b1, 1'b0, 32'h0000_1004, wdata, 4'b0011}) begin
                errors++;
                $display("FAIL dwrite_bus c%0d: got %h expected %h", j,
                         {s_write, s_read, s_address, s_writedata, s_byteenable},
                         {1'b1, 1'b0, 32'h0000_1004, wdata, 4'b0011});
            end
            checks++;
            if ({d_waitrequest, i_waitrequest} !== {1'(j < 2), 1'b1}) begin
                errors++;
                $display("FAIL dwrite_wait c%0d: got %b expected %b", j,
                         {d_waitrequest, i_waitrequest}, {1'(j < 2), 1'b1});
            end
        end
        next_cycle();
        d_writedata = ~wdata; s_waitrequest = 1'b1;
        sample();
        checks++;
        if (s_write !== 1'b0) begin
            errors++;
            $display("FAIL dwrite_gap: got s_write=%b expected 0", s_write);
        end
        next_cycle();
        s_waitrequest = 1'b0;
        sample();
        checks++;
        if ({s_write, s_writedata, d_waitrequest} !== {1'b1, ~wdata, 1'b0}) begin
            errors++;
            $display("FAIL dwrite_second: got %h expected %h",
                     {s_write, s_writedata, d_waitrequest}, {1'b1, ~wdata, 1'b0});
        end
        next_cycle();
        idle_masters(); s_waitrequest = 1'b1;
        sample();
        checks++;
        if (s_write !== 1'b0) begin
            errors++;
            $display("FAIL dwrite_idle_after: got s_write=%b expected 0", s_write);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        w = $urandom;
        next_cycle();
        i_read = 1'b1; i_address = {1'b0, 31'($urandom)}; s_waitrequest = 1'b1;
        sample();
        for (int j = 0; j < int'(TO); j++) begin
            next_cycle();
            sample();
            checks++;
            if ({s_read, i_waitrequest, bus_error} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_stall c%0d: got %b expected 110", j, {s_read, i_waitrequest, bus_error});
            end
        end
        next_cycle();
        sample();
        checks++;
        if ({s_read, s_write} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_abort_strobes: got %b expected 00", {s_read, s_write});
        end
        checks++;
        if ({i_waitrequest, i_readdata} !== {1'b0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL timeout_abort_resp: got %h expected %h", {i_waitrequest, i_readdata}, {1'b0, 32'hFFFF_FFFF});
        end
        checks++;
        if ({d_waitrequest, bus_error} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_abort_flag: got %b expected 11", {d_waitrequest, bus_error});
        end
        next_cycle();
        i_read = 1'b0;
        sample();
        checks++;
        if ({s_read, i_waitrequest, bus_error} !== 3'b011) begin
            errors++;
            $display("FAIL timeout_idle: got %b expected 011", {s_read, i_waitrequest, bus_error});
        end
        next_cycle();
        d_read = 1'b1; d_address = 32'h0000_2000;
        sample();
        next_cycle();
        s_waitrequest = 1'b0; s_readdata = w;
        sample();
        checks++;
        if ({d_waitrequest, d_readdata, bus_error} !== {1'b0, w, 1'b1}) begin
            errors++;
            $display("FAIL timeout_sticky_xfer: got %h expected %h", {d_waitrequest, d_readdata, bus_error}, {1'b0, w, 1'b1});
        end
        next_cycle();
        idle_masters(); s_waitrequest = 1'b1;
        sample();
        checks++;
        if (bus_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", bus_error);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b, w;
        b = {1'b0, 31'($urandom)}; w = $urandom;
        next_cycle();
        d_read = 1'b1; d_address = 32'h0000_3000; s_waitrequest = 1'b1;
        sample();
        next_cycle();
        sample();
        checks++;
        if ({s_read, d_waitrequest} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_granted: got %b expected 11", {s_read, d_waitrequest});
        end
        next_cycle();
        reset = 1'b0;
        sample();
        next_cycle();
        reset = 1'b1; d_read = 1'b0; i_read = 1'b1; i_address = b;
        sample();
        checks++;
        if ({s_read, s_write, s_address, s_writedata, s_byteenable} !== 70'h0) begin
            errors++;
            $display("FAIL rstmid_s_bus: got %h expected 0", {s_read, s_write, s_address, s_writedata, s_byteenable});
        end
        checks++;
        if ({i_waitrequest, d_waitrequest, i_readdata, d_readdata, bus_error} !== {2'b11, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_resp: got %h expected %h",
                     {i_waitrequest, d_waitrequest, i_readdata, d_readdata, bus_error}, {2'b11, 64'h0, 1'b0});
        end
        next_cycle();
        s_waitrequest = 1'b0; s_readdata = w;
        sample();
        checks++;
        if ({s_read, s_address, i_waitrequest, i_readdata} !== {1'b1, b, 1'b0, w}) begin
            errors++;
            $display("FAIL rstmid_igrant: got %h expected %h",
                     {s_read, s_address, i_waitrequest, i_readdata}, {1'b1, b, 1'b0, w});
        end
        next_cycle();
        idle_masters(); s_waitrequest = 1'b1;
        sample();
        checks++;
        if (bus_error !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_bus_error: got %b expected 0", bus_error);
        end
    endtask

    task automatic test_random();
        logic order[$];
        logic turn_i;
        logic o;
        logic exp_wait;
        logic [31:0] word;
        txn_t t;
        int ni, nd, pi, pd;
        iq.delete(); dq.delete();
        ni = $urandom_range(2, 6); nd = $urandom_range(2, 6);
        for (int n = 0; n < ni; n++) iq.push_back(rand_txn(1'b0));
        for (int n = 0; n < nd; n++) dq.push_back(rand_txn(1'b1));
        // Both masters always have work queued, so every decision with both pending is a tie.
        pi = 0; pd = 0; turn_i = 1'b1;
        while (pi < ni || pd < nd) begin
            if (pi < ni && pd < nd) begin
                order.push_back(turn_i);
                if (turn_i) pi++; else pd++;
                turn_i = !turn_i;
            end else if (pi < ni) begin
                order.push_back(1'b1); pi++;
            end else begin
                order.push_back(1'b0); pd++;
            end
        end
        ci = 0; cd = 0;
        next_cycle();
        reset = 1'b0; idle_masters(); s_waitrequest = 1'b1;
        sample();
        next_cycle();
        reset = 1'b1; drive_heads();
        sample();
        checks++;
        if ({s_read, s_write, bus_error} !== 3'b000) begin
            errors++;
            $display("FAIL rand_start: got %b expected 000", {s_read, s_write, bus_error});
        end
        foreach (order[k]) begin
            o = order[k];
            t = o ? iq[ci] : dq[cd];
            for (int j = 0; j <= int'(t.stall); j++) begin
                next_cycle();
                exp_wait = (j < int'(t.stall));
                word = $urandom;
                s_waitrequest = exp_wait; s_readdata = word;
                sample();
                checks++;
                if ({s_address, s_read, s_write, s_writedata, s_byteenable} !== {t.addr, !t.wr, t.wr, t.wdata, t.be}) begin
                    errors++;
                    $display("FAIL rand_bus x%0d c%0d: got %h expected %h", k, j,
                             {s_address, s_read, s_write, s_writedata, s_byteenable}, {t.addr, !t.wr, t.wr, t.wdata, t.be});
                end
                checks++;
                if (o) begin
                    if ({i_waitrequest, i_readdata, d_waitrequest, d_readdata} !== {exp_wait, word, 1'b1, 32'h0}) begin
                        errors++;
                        $display("FAIL rand_resp_i x%0d c%0d: got %h expected %h", k, j,
                                 {i_waitrequest, i_readdata, d_waitrequest, d_readdata}, {exp_wait, word, 1'b1, 32'h0});
                    end
                end else begin
                    if ({d_waitrequest, d_readdata, i_waitrequest, i_readdata} !== {exp_wait, word, 1'b1, 32'h0}) begin
                        errors++;
                        $display("FAIL rand_resp_d x%0d c%0d: got %h expected %h", k, j,
                                 {d_waitrequest, d_readdata, i_waitrequest, i_readdata}, {exp_wait, word, 1'b1, 32'h0});
                    end
                end
            end
            if (o) ci++; else cd++;
            next_cycle();
            drive_heads(); s_waitrequest = 1'b1;
            sample();
            checks++;
            if ({s_read, s_write} !== 2'b00) begin
                errors++;
                $display("FAIL rand_gap x%0d: got %b expected 00", k, {s_read, s_write});
            end
        end
        checks++;
        if (bus_error !== 1'b0) begin
            errors++;
            $display("FAIL rand_bus_error: got %b expected 0", bus_error);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_masters();
        s_waitrequest = 1'b1;
        s_readdata = '0;
        ci = 0; cd = 0;
        test_reset();
        test_single_iread();
        test_tie();
        test_dwrite();
        test_timeout();
        test_reset_mid();
        for (int n = 0; n < 3; n++) test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
